alu_arbiter_4: RTL and testbench

ALU_ARBITER_4 -- requirements
Module: alu_arbiter_4

---
 rtl/alu_arbiter_4.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter_4.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_4.sv
// rtl/alu_arbiter_4.sv - four-requester round-robin arbiter sharing one 16-bit ALU
module alu_arbiter_4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        res_ack,
  input  logic [15:0] alu_result,
  output logic [3:0]  gnt,
  output logic [2:0]  alu_op,
  output logic        alu_en,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [1:0]  res_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_data_q, res_data_d;
  logic [1:0]  res_id_q, res_id_d;

  logic [3:0][2:0]  op_v;
  logic [3:0][15:0] a_v;
  logic [3:0][15:0] b_v;
  logic [7:0]       req_dbl;
  logic [3:0]       rot;
  logic [1:0]       win_off;
  logic [1:0]       win_idx;

  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr_q +: 4];

  always_comb begin
    win_off = 2'd0;
    casez (rot)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
    win_idx = ptr_q + win_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (res_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_en = (state_q == S_ISSUE);
    busy   = (state_q != S_IDLE);
  end

  // Operands are latched at the grant edge; later request changes cannot reach the ALU.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d    = 4'b0001 << win_idx;
          alu_op_d = op_v[win_idx];
          alu_a_d  = a_v[win_idx];
          alu_b_d  = b_v[win_idx];
          res_id_d = win_idx;
          ptr_d    = win_idx + 2'd1;
        end
      end
      S_ISSUE: begin
        res_data_d  = alu_result;
        res_valid_d = 1'b1;
      end
      S_RESP: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          gnt_d       = 4'b0000;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      gnt_q       <= 4'd0;
      alu_op_q    <= 3'd0;
      alu_a_q     <= 16'd0;
      alu_b_q     <= 16'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      res_id_q    <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_arbiter_4.sv
// tb/tb_alu_arbiter_4.sv - directed vector bench for alu_arbiter_4
module tb_alu_arbiter_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_ack;
  logic [15:0] alu_result;
  logic [3:0]  gnt;
  logic [2:0]  alu_op;
  logic        alu_en;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .res_ack    (res_ack),
    .alu_result (alu_result),
    .gnt        (gnt),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: 0 and, 1 or, 2 add, 3 sub, 4 xor, 5 not a, 6 pass a, 7 pass b; idle output is zero.
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  assign alu_result = alu_en ? alu_f(alu_op, alu_a, alu_b) : 16'h0000;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  win;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    bit          mutate;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_lanes(input vec_t v);
    int w;
    w = int'(v.win);
    for (int i = 0; i < 4; i++) begin
      req_op[i*3 +: 3]  = 3'd7;
      req_a[i*16 +: 16] = 16'hA0A0 + 16'(i);
      req_b[i*16 +: 16] = 16'hB0B0 + 16'(i);
    end
    req_op[w*3 +: 3]  = v.op;
    req_a[w*16 +: 16] = v.a;
    req_b[w*16 +: 16] = v.b;
  endtask

  // Full transaction with res_ack raised during ISSUE, where it must be ignored.
  task automatic run_txn(input vec_t v);
    int w;
    w = int'(v.win);
    req = v.req;
    load_lanes(v);
    res_ack = 1'b0;
    @(posedge clk); #1;
    chk("grant_gnt", 64'(gnt), 64'(4'b0001 << v.win));
    chk("grant_alu", {alu_op, alu_a, alu_b, alu_en, busy, res_valid}, {v.op, v.a, v.b, 1'b1, 1'b1, 1'b0});
    if (v.mutate) begin
      req[w]            = 1'b0;
      req_a[w*16 +: 16] = ~v.a;
      req_op[w*3 +: 3]  = v.op + 3'd1;
    end
    res_ack = 1'b1;
    @(posedge clk); #1;
    chk("resp_data", {res_valid, res_data, res_id, alu_en, busy}, {1'b1, v.res, v.win, 1'b0, 1'b1});
    chk("resp_gnt", 64'(gnt), 64'(4'b0001 << v.win));
    @(posedge clk); #1;
    chk("release", {gnt, res_valid, busy}, {4'b0000, 1'b0, 1'b0});
    res_ack = 1'b0;
    req     = 4'b0000;
  endtask

  initial begin
    vec_t mv;
    vecs[0] = '{4'b0001, 2'd0, 3'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1] = '{4'b0001, 2'd0, 3'd3, 16'h000A, 16'h0003, 16'h0007, 1'b0};
    vecs[2] = '{4'b1001, 2'd3, 3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[3] = '{4'b1001, 2'd0, 3'd1, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
    vecs[4] = '{4'b0110, 2'd1, 3'd4, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b0};
    vecs[5] = '{4'b0110, 2'd2, 3'd5, 16'h00FF, 16'h5555, 16'hFF00, 1'b1};
    vecs[6] = '{4'b0011, 2'd0, 3'd2, 16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    vecs[7] = '{4'b1111, 2'd1, 3'd7, 16'h1357, 16'hABCD, 16'hABCD, 1'b0};

    rst_n   = 1'b0;
    req     = 4'b0000;
    req_op  = '0;
    req_a   = '0;
    req_b   = '0;
    res_ack = 1'b0;
    #3;
    chk("reset_outputs", {gnt, alu_op, alu_en, alu_a, alu_b, res_valid, res_data, res_id, busy}, 60'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with stray acknowledges
    for (int i = 0; i < 20; i++) begin
      res_ack = i[0];
      @(posedge clk); #1;
      chk("idle_stray_ack", {gnt, busy, res_valid}, 6'd0);
    end
    res_ack = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Ack stall: pointer is 2, only requester 0 asks
    mv = '{4'b0001, 2'd0, 3'd2, 16'h0001, 16'h0001, 16'h0002, 1'b0};
    req = mv.req;
    load_lanes(mv);
    @(posedge clk); #1;
    chk("stall_grant", 64'(gnt), 64'(4'b0001));
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {res_valid, res_data, gnt, busy}, {1'b1, 16'h0002, 4'b0001, 1'b1});
    end
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    req     = 4'b0000;
    chk("stall_release", {gnt, busy, res_valid}, 6'd0);

    // Reset during RESP: pointer moves to 3 on this grant, then reset must return it to 0
    mv = '{4'b0100, 2'd2, 3'd2, 16'h0010, 16'h0020, 16'h0030, 1'b0};
    req = mv.req;
    load_lanes(mv);
    @(posedge clk); #1;
    chk("midop_grant", 64'(gnt), 64'(4'b0100));
    @(posedge clk); #1;
    chk("midop_resp", {res_valid, res_data}, {1'b1, 16'h0030});
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_async", {gnt, alu_op, alu_en, alu_a, alu_b, res_valid, res_data, res_id, busy}, 60'd0);
    #2 rst_n = 1'b1;
    run_txn('{4'b1100, 2'd2, 3'd2, 16'h0007, 16'h0008, 16'h000F, 1'b0});

    // All requesting with ack held high: period-3 grants in order 0,1,2,3,0
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_op[i*3 +: 3]  = 3'd2;
      req_a[i*16 +: 16] = 16'(i);
      req_b[i*16 +: 16] = 16'h0100;
    end
    res_ack = 1'b1;
    for (int c = 0; c < 15; c++) begin
      logic [3:0] exp_g;
      @(posedge clk); #1;
      exp_g = (c % 3 == 2) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
      chk("rr_gnt", 64'(gnt), 64'(exp_g));
      chk("rr_busy", 64'(busy), 64'(exp_g != 4'b0000));
    end
    req     = 4'b0000;
    res_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
